// File: rtl/bus_downsizer_if.sv
// Stream port bundle for bus_downsizer: wide input word channel and narrow output slice channel.
// A transfer happens on a channel in any cycle where its val and rdy are both high at the rising clock edge;
// a source holds val and its data stable until that transfer, and val never depends on rdy.
interface bus_downsizer_if #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8
);
  logic                    s_val;
  logic [S_DATA_WIDTH-1:0] s_data;
  logic                    s_rdy;
  logic                    m_val;
  logic [M_DATA_WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    m_rdy;

  // Downsizer side of the bundle
  modport slave (
    input  s_val, s_data, m_rdy,
    output s_rdy, m_val, m_data, m_last
  );

  // Environment side: drives words in and accepts slices out
  modport master (
    output s_val, s_data, m_rdy,
    input  s_rdy, m_val, m_data, m_last
  );
endinterface

// File: rtl/bus_downsizer.sv
// Serialises one S_DATA_WIDTH word per input handshake into RATIO M_DATA_WIDTH slices,
// with zero bubbles between words when both sides stream continuously.
module bus_downsizer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8,
  parameter int MSB_FIRST    = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  bus_downsizer_if.slave   bus,
  output logic             state_dbg
);

  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int CW    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [S_DATA_WIDTH-1:0] word;
  logic                    m_val_q;
  logic                    m_last_q;
  logic                    active_q;

  logic                    last_beat;
  logic                    s_rdy_c;
  logic                    s_take;
  logic [CW-1:0]           cnt_nxt;
  int unsigned             slice_idx;
  logic [S_DATA_WIDTH-1:0] word_shr;

  assign last_beat = (state == SEND) && (cnt == LAST_CNT);
  // active_q keeps s_rdy low until the first edge after reset release; the m_rdy term
  // lets a new word load on the same edge the final slice leaves.
  assign s_rdy_c   = active_q && ((state == IDLE) || (last_beat && bus.m_rdy));
  assign s_take    = bus.s_val && s_rdy_c;
  assign cnt_nxt   = cnt + 1'b1;

  always_comb begin
    slice_idx = 32'(cnt);
    if (MSB_FIRST != 0) slice_idx = 32'(RATIO - 1) - 32'(cnt);
    word_shr = word >> (slice_idx * 32'(M_DATA_WIDTH));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      word     <= '0;
      m_val_q  <= 1'b0;
      m_last_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state)
        IDLE: begin
          if (s_take) begin
            word     <= bus.s_data;
            cnt      <= '0;
            m_val_q  <= 1'b1;
            m_last_q <= (LAST_CNT == '0);
            state    <= SEND;
          end
        end
        SEND: begin
          if (bus.m_rdy) begin
            if (cnt != LAST_CNT) begin
              cnt      <= cnt_nxt;
              m_last_q <= (cnt_nxt == LAST_CNT);
            end else if (s_take) begin
              word     <= bus.s_data;
              cnt      <= '0;
              m_last_q <= 1'b0;
            end else begin
              cnt      <= '0;
              m_val_q  <= 1'b0;
              m_last_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_rdy  = s_rdy_c;
  assign bus.m_val  = m_val_q;
  assign bus.m_last = m_last_q;
  assign bus.m_data = word_shr[M_DATA_WIDTH-1:0];
  assign state_dbg  = state;

endmodule

// File: doc/bus_downsizer.md
# bus_downsizer

Width-reducing stream stage that accepts one wide word per valid/ready handshake and emits it as RATIO narrow slices over a valid/ready output port. It sits directly upstream of the bus upsizer in the datapath:
- 32-bit words from the wide domain are serialised to 8-bit beats.
- The upsizer reassembles those beats, so a downsizer→upsizer chain is lossless.
- Default slice order is MSB-first, so the upsizer's packing restores the original word.

## Interface
- S_DATA_WIDTH, 32, width of input word.
- M_DATA_WIDTH, 8, width of output slice; S_DATA_WIDTH must be an integer multiple ≥2 of it (RATIO = S_DATA_WIDTH/M_DATA_WIDTH).
- MSB_FIRST, 1, 1: slice order is most-significant slice first; 0: least-significant slice first.
- clock  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_val  input  1  input word valid.
- s_data  input  S_DATA_WIDTH  input word.
- s_rdy  output  1  block can accept a word this cycle.
- m_val  output  1  output slice valid.
- m_data  output  M_DATA_WIDTH  output slice.
- m_last  output  1  high with the final slice of each word.
- m_rdy  input  1  downstream accepts slice this cycle.

## Operation
- Internal state: word register, slice counter cnt (clog2(RATIO) bits, min 1), FSM {IDLE, SEND}.
- IDLE:
  - s_rdy=1, m_val=0.
  - On s_val&&s_rdy: capture s_data, cnt←0, go SEND.
- SEND:
  - m_val=1; m_data = slice cnt of held word.
    - MSB_FIRST=1: slice 0 = s_data[S-1 -: M].
    - MSB_FIRST=0: slice 0 = s_data[M-1:0].
  - m_last = (cnt==RATIO-1).
  - m_val&&m_rdy with cnt<RATIO-1: cnt←cnt+1.
  - m_val&&m_rdy with cnt==RATIO-1 (last slice taken):
    - s_val=1: load new word in the same cycle, cnt←0, stay SEND.
    - s_val=0: go IDLE.
  - No m_rdy: hold m_data, m_last, cnt unchanged.
- s_rdy = (state==IDLE) || (state==SEND && cnt==RATIO-1 && m_rdy).
  - This is a combinational path m_rdy→s_rdy, accepted in order to get zero bubbles.
- m_data, m_last and m_val depend only on registered state. No combinational path from s_* to m_*.
- Held word is never modified except on an accepted input handshake.
- cnt never exceeds RATIO-1. There is no wrap without a handshake.

## Timing
- Reset values (async, while reset_n=0): state=IDLE, cnt=0, word register=0, m_val=0, m_last=0, m_data=0, s_rdy=0 during reset. s_rdy=1 from the first clock edge after reset_n release.
- Latency: word accepted at edge N → slice 0 valid in cycle N+1.
- Throughput with m_rdy held 1 and s_val held 1:
  - One slice per cycle, one word per RATIO cycles.
  - No idle cycle between words.
- Under backpressure, m_val stays high and slices are stable until accepted (valid never drops without a handshake).
- s_val with s_rdy=0: word not captured; upstream must hold it.
- Reset asserted mid-word: the partial word is discarded. After release, the next output is slice 0 of a newly accepted word.

## Test plan
- MSB_FIRST=1, send 0xAABBCCDD, m_rdy=1:
  - m_data AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept.
  - m_last only with DD.
  - s_rdy low during AA..CC.
- Back-to-back 0x11223344, 0x55667788, s_val and m_rdy held 1:
  - 8 consecutive valid beats 11..44,55..88, no gap.
  - Second word accepted on the cycle 44 is taken.
- Backpressure: send 0xDEADBEEF, m_rdy pattern 1,0,0,1,0,1,1:
  - Beats DE,AD,BE,EF each held stable while m_rdy=0.
  - Word completes after exactly 4 handshakes.
- MSB_FIRST=0, send 0x01020304 → m_data 04,03,02,01, m_last with 01.
- Reset mid-word: assert reset_n=0 after slice BB of 0xAABBCCDD.
  - m_val=0 immediately (async).
  - After release, send 0x0A0B0C0D → first beat 0A.
- Loopback into the upsizer with random words and random m_rdy/s_val stalls: every 32-bit word reproduced in order, none lost or duplicated.
